// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared widths, turn tokens and port select codes for the NoC output port
package noc_pkg;

  localparam int FLIT_W = 8;

  // One-hot arbitration tokens, rotated right each cycle
  localparam logic [4:0] TURN_N = 5'b10000;
  localparam logic [4:0] TURN_S = 5'b01000;
  localparam logic [4:0] TURN_E = 5'b00100;
  localparam logic [4:0] TURN_W = 5'b00010;
  localparam logic [4:0] TURN_L = 5'b00001;

  typedef enum logic [2:0] {
    SEL_N = 3'b000,
    SEL_S = 3'b001,
    SEL_E = 3'b010,
    SEL_W = 3'b011,
    SEL_L = 3'b100
  } sel_e;

  // A source select is bad when it names this port (U-turn) or is not a known port
  function automatic logic sel_is_bad(input logic [2:0] sel, input logic [2:0] port_id);
    return (sel == port_id) || (sel > SEL_L);
  endfunction

endpackage

// File: rtl/noc_fifo.sv
// rtl/noc_fifo.sv - synchronous staging FIFO with registered occupancy count
module noc_fifo
  import noc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = FLIT_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Next storage, pointer and occupancy; pointers wrap at DEPTH, not at a power of two
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state register; reset empties the buffer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/noc_output_port.sv
// rtl/noc_output_port.sv - router output port: staging FIFO, credit flow control, link register, turn token
module noc_output_port
  import noc_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter int         CREDITS    = 4,
  parameter logic [2:0] PORT_ID    = 3'b000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [FLIT_W-1:0]            in_data,
  input  logic                         in_enable,
  input  logic [2:0]                   in_select,
  output logic                         port_full,
  output logic [4:0]                   turn,
  output logic [FLIT_W-1:0]            link_data_o,
  output logic                         link_valid_o,
  input  logic                         link_credit_i,
  output logic [$clog2(CREDITS+1)-1:0] credit_cnt,
  output logic                         drop_err,
  output logic                         credit_err
);

  localparam int CCW = $clog2(CREDITS + 1);
  localparam int FCW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CCW-1:0] CREDIT_MAX = CCW'(CREDITS);
  localparam logic [FCW-1:0] FIFO_FULL  = FCW'(FIFO_DEPTH);

  logic [4:0]        turn_q, turn_d;
  logic [CCW-1:0]    credit_q, credit_d;
  logic [FLIT_W-1:0] link_data_q, link_data_d;
  logic              link_valid_q, link_valid_d;
  logic              drop_err_q, drop_err_d;
  logic              credit_err_q, credit_err_d;

  logic [FLIT_W-1:0] fifo_rdata;
  logic [FCW-1:0]    fifo_count;
  logic              unused_fifo_full;
  logic              fifo_empty;
  logic              push, pop;

  // Full comes from the registered count, so a same-cycle pop never frees a slot early
  assign port_full = (fifo_count == FIFO_FULL);
  assign push      = in_enable && !port_full;
  assign pop       = !fifo_empty && (credit_q != '0);

  noc_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FLIT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (in_data),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (unused_fifo_full),
    .empty (fifo_empty)
  );

  // Arbitration token rotates right every cycle regardless of traffic
  always_comb begin
    turn_d = {turn_q[0], turn_q[4:1]};
  end

  // Credit accounting: pop spends one, a return pulse restores one, both cancel
  always_comb begin
    credit_d = credit_q;
    case ({pop, link_credit_i})
      2'b10:   credit_d = credit_q - CCW'(1);
      2'b01:   credit_d = (credit_q == CREDIT_MAX) ? credit_q : credit_q + CCW'(1);
      default: credit_d = credit_q;
    endcase
  end

  // Link register: a popped flit is presented for exactly one cycle, data holds otherwise
  always_comb begin
    link_valid_d = pop;
    link_data_d  = pop ? fifo_rdata : link_data_q;
  end

  // Sticky error flags for dropped writes, credit overflow and bad source selects
  always_comb begin
    drop_err_d   = drop_err_q | (in_enable && port_full);
    credit_err_d = credit_err_q
                 | (link_credit_i && !pop && (credit_q == CREDIT_MAX))
                 | (in_enable && sel_is_bad(in_select, PORT_ID));
  end

  // State register; async reset also kills link_valid_o immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      turn_q       <= TURN_N;
      credit_q     <= CREDIT_MAX;
      link_data_q  <= '0;
      link_valid_q <= 1'b0;
      drop_err_q   <= 1'b0;
      credit_err_q <= 1'b0;
    end else begin
      turn_q       <= turn_d;
      credit_q     <= credit_d;
      link_data_q  <= link_data_d;
      link_valid_q <= link_valid_d;
      drop_err_q   <= drop_err_d;
      credit_err_q <= credit_err_d;
    end
  end

  assign turn         = turn_q;
  assign credit_cnt   = credit_q;
  assign link_data_o  = link_data_q;
  assign link_valid_o = link_valid_q;
  assign drop_err     = drop_err_q;
  assign credit_err   = credit_err_q;

endmodule

// File: tb/tb_noc_output_port.sv
// tb/tb_noc_output_port.sv - directed self-checking bench for noc_output_port
module tb_noc_output_port;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_enable;
  logic [2:0] in_select;
  logic       port_full;
  logic [4:0] turn;
  logic [7:0] link_data_o;
  logic       link_valid_o;
  logic       link_credit_i;
  logic [2:0] credit_cnt;
  logic       drop_err;
  logic       credit_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  noc_output_port #(
    .FIFO_DEPTH (4),
    .CREDITS    (4),
    .PORT_ID    (3'b000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_data       (in_data),
    .in_enable     (in_enable),
    .in_select     (in_select),
    .port_full     (port_full),
    .turn          (turn),
    .link_data_o   (link_data_o),
    .link_valid_o  (link_valid_o),
    .link_credit_i (link_credit_i),
    .credit_cnt    (credit_cnt),
    .drop_err      (drop_err),
    .credit_err    (credit_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] ed;
    logic [4:0] et;

    rst = 1'b1; in_data = '0; in_enable = 1'b0; in_select = 3'b100; link_credit_i = 1'b0;
    #12;
    check("rst_turn", 32'(turn), 32'h10);
    check("rst_credit", 32'(credit_cnt), 32'd4);
    check("rst_full", 32'(port_full), 32'd0);
    check("rst_valid", 32'(link_valid_o), 32'd0);
    check("rst_data", 32'(link_data_o), 32'h00);
    check("rst_errs", {30'd0, drop_err, credit_err}, 32'd0);

    tick; rst = 1'b0;
    check("turn_hold", 32'(turn), 32'h10);
    tick; check("turn_first", 32'(turn), 32'h08);
    tick; check("turn_second", 32'(turn), 32'h04);

    // single flit latency
    in_data = 8'h23; in_enable = 1'b1;
    tick; in_enable = 1'b0;
    check("single_t1_valid", 32'(link_valid_o), 32'd0);
    tick;
    check("single_t2_valid", 32'(link_valid_o), 32'd1);
    check("single_t2_data", 32'(link_data_o), 32'h23);
    check("single_t2_credit", 32'(credit_cnt), 32'd3);
    tick;
    check("single_idle_valid", 32'(link_valid_o), 32'd0);
    check("single_hold_data", 32'(link_data_o), 32'h23);
    link_credit_i = 1'b1; tick; link_credit_i = 1'b0;
    check("single_credit_back", 32'(credit_cnt), 32'd4);

    // credit exhaustion: five back-to-back writes, four credits
    for (int k = 0; k < 5; k++) begin
      in_data = 8'(8'hA0 + k); in_enable = 1'b1;
      tick;
      if (k >= 1) begin
        ed = 8'(8'hA0 + k - 1);
        check("exh_valid", 32'(link_valid_o), 32'd1);
        check("exh_data", 32'(link_data_o), 32'(ed));
      end
    end
    in_enable = 1'b0;
    tick;
    check("exh_held_valid", 32'(link_valid_o), 32'd0);
    check("exh_credit0", 32'(credit_cnt), 32'd0);
    check("exh_held_data", 32'(link_data_o), 32'hA3);
    link_credit_i = 1'b1; tick; link_credit_i = 1'b0;
    check("exh_ret_credit", 32'(credit_cnt), 32'd1);
    check("exh_ret_valid", 32'(link_valid_o), 32'd0);
    tick;
    check("exh_fifth_valid", 32'(link_valid_o), 32'd1);
    check("exh_fifth_data", 32'(link_data_o), 32'hA4);
    check("exh_fifth_credit", 32'(credit_cnt), 32'd0);

    // full and drop with no credits
    for (int k = 0; k < 4; k++) begin
      in_data = 8'(8'hB0 + k); in_enable = 1'b1;
      tick;
      if (k == 2) check("full_at3", 32'(port_full), 32'd0);
    end
    check("full_at4", 32'(port_full), 32'd1);
    check("drop_before", 32'(drop_err), 32'd0);
    in_data = 8'hBF; tick; in_enable = 1'b0;
    check("drop_set", 32'(drop_err), 32'd1);
    check("drop_full_still", 32'(port_full), 32'd1);
    link_credit_i = 1'b1; tick;
    check("drain_credit1", 32'(credit_cnt), 32'd1);
    check("full_in_pop_cycle", 32'(port_full), 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick;
      ed = 8'(8'hB0 + k);
      check("drain_valid", 32'(link_valid_o), 32'd1);
      check("drain_data", 32'(link_data_o), 32'(ed));
      check("drain_credit", 32'(credit_cnt), 32'd1);
    end
    link_credit_i = 1'b0; tick;
    check("drain_last", 32'(link_data_o), 32'hB3);
    check("drain_last_credit", 32'(credit_cnt), 32'd0);
    tick;
    check("drain_dropped_gone", 32'(link_valid_o), 32'd0);
    link_credit_i = 1'b1; repeat (4) tick; link_credit_i = 1'b0;
    check("refill_credit", 32'(credit_cnt), 32'd4);
    check("refill_no_err", 32'(credit_err), 32'd0);

    // simultaneous pop and credit return at two credits
    for (int k = 0; k < 3; k++) begin
      in_data = 8'(8'hC0 + k); in_enable = 1'b1; tick;
    end
    in_enable = 1'b0;
    check("simul_pre_credit", 32'(credit_cnt), 32'd2);
    link_credit_i = 1'b1; tick; link_credit_i = 1'b0;
    check("simul_credit", 32'(credit_cnt), 32'd2);
    check("simul_data", 32'(link_data_o), 32'hC2);
    link_credit_i = 1'b1; tick; tick; link_credit_i = 1'b0;
    check("simul_refill", 32'(credit_cnt), 32'd4);

    // credit overflow with empty FIFO
    link_credit_i = 1'b1; tick; link_credit_i = 1'b0;
    check("ovf_credit", 32'(credit_cnt), 32'd4);
    check("ovf_err", 32'(credit_err), 32'd1);
    check("drop_sticky", 32'(drop_err), 32'd1);

    // reset mid-traffic
    in_data = 8'hD0; in_enable = 1'b1; tick;
    in_data = 8'hD1; tick; in_enable = 1'b0;
    check("mid_pre_valid", 32'(link_valid_o), 32'd1);
    rst = 1'b1; #1;
    check("mid_valid_async", 32'(link_valid_o), 32'd0);
    check("mid_data_async", 32'(link_data_o), 32'h00);
    tick; rst = 1'b0;
    check("mid_turn", 32'(turn), 32'h10);
    check("mid_credit", 32'(credit_cnt), 32'd4);
    check("mid_full", 32'(port_full), 32'd0);
    check("mid_errs", {30'd0, drop_err, credit_err}, 32'd0);
    et = 5'b10000;
    for (int i = 0; i < 6; i++) begin
      tick;
      et = {et[0], et[4:1]};
      check("rot_turn", 32'(turn), 32'(et));
      check("mid_flush", 32'(link_valid_o), 32'd0);
    end

    // U-turn select
    in_select = 3'b000; in_data = 8'hE0; in_enable = 1'b1; tick; in_enable = 1'b0;
    check("uturn_err", 32'(credit_err), 32'd1);
    rst = 1'b1; tick; rst = 1'b0;
    check("uturn_clr", 32'(credit_err), 32'd0);
    // invalid select code
    in_select = 3'b101; in_enable = 1'b1; tick; in_enable = 1'b0;
    check("badsel_err", 32'(credit_err), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/noc_output_port.md
NOC_OUTPUT_PORT -- requirements
Module: noc_output_port

Interface
REQ-001 SHALL provide parameter FIFO_DEPTH, default 4: staging FIFO entries.
REQ-002 SHALL provide parameter CREDITS, default 4: downstream input-buffer slots, initial credit count.
REQ-003 SHALL provide parameter PORT_ID, default 3'b000: this port's select code (N=000, S=001, E=010, W=011, L=100).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_data  input  8  flit from the routing logic; [7:4] X dest, [3:0] Y dest.
REQ-007 in_enable  input  1  write strobe; the routing logic's port_enable for this port.
REQ-008 in_select  input  3  source port code of the flit; used for error checking only.
REQ-009 port_full  output  1  staging FIFO full; feeds the routing logic's port_full.
REQ-010 turn  output  5  one-hot arbitration token (N=10000, S=01000, E=00100, W=00010, L=00001).
REQ-011 link_data_o  output  8  flit to the downstream router.
REQ-012 link_valid_o  output  1  link_data_o valid, one cycle per flit.
REQ-013 link_credit_i  input  1  credit return pulse from downstream, one per freed slot.
REQ-014 credit_cnt  output  $clog2(CREDITS+1)  current credits.
REQ-015 drop_err  output  1  sticky: a write was attempted while full.
REQ-016 credit_err  output  1  sticky: a credit return arrived at CREDITS, or in_select was a U-turn (equal to PORT_ID) or invalid (>100).

Function
REQ-017 turn SHALL rotate one position right every cycle (10000->01000->00100->00010->00001->10000), independent of traffic.
REQ-018 in_enable with port_full=0 SHALL push in_data at that clock edge.
REQ-019 in_enable with port_full=1 SHALL discard in_data, leave the FIFO unchanged and set drop_err.
REQ-020 port_full SHALL be decoded from registered FIFO count only (count==FIFO_DEPTH).
REQ-021 port_full SHALL stay asserted in a cycle in which a pop occurs.
REQ-022 A pop SHALL occur in any cycle with FIFO non-empty and credit_cnt>0.
REQ-023 A pop SHALL register the head flit into link_data_o, set link_valid_o=1 next cycle, and decrement credits.
REQ-024 With no pop, link_valid_o SHALL be 0 and link_data_o SHALL hold its last value.
REQ-025 Latency: a flit written into an empty FIFO with credits available in cycle t SHALL appear with link_valid_o=1 in cycle t+2.
REQ-026 Throughput: one flit per cycle while credits last.
REQ-027 Simultaneous push and pop SHALL be legal; count unchanged.
REQ-028 A push to an empty FIFO SHALL NOT bypass the FIFO.
REQ-029 Credit update: pop only -> -1; link_credit_i only -> +1; both -> unchanged.
REQ-030 credit_cnt SHALL never exceed CREDITS: link_credit_i without a pop at credit_cnt==CREDITS SHALL leave the count unchanged and set credit_err.
REQ-031 credit_cnt SHALL never underflow; no pop occurs at 0.
REQ-032 FIFO SHALL preserve order; pointers wrap modulo FIFO_DEPTH.

Reset
REQ-033 rst SHALL set:
  - FIFO empty, port_full=0
  - turn=10000
  - credit_cnt=CREDITS
  - link_valid_o=0, link_data_o=8'h00
  - drop_err=0, credit_err=0
REQ-034 rst mid-operation SHALL discard all staged flits; link_valid_o SHALL drop immediately (asynchronous).
REQ-035 The first rising edge after rst deasserts SHALL rotate turn to 01000.

Structure
REQ-036 Package noc_pkg SHALL hold:
  - FLIT_W=8
  - turn encodings TURN_N..TURN_L
  - select codes SEL_N..SEL_L
REQ-037 Staging buffer SHALL be a sub-module noc_fifo (synchronous, parameterised depth and width, push/pop/count/full/empty).
REQ-038 Credit counter, turn rotator and link register SHALL live in noc_output_port.

Verification
REQ-039 Reset: assert rst mid-traffic -> link_valid_o=0 at once; after release turn=10000, credit_cnt=4, port_full=0, errors 0.
REQ-040 Single flit: in_data=8'h23, in_enable=1 in cycle t -> link_data_o=8'h23, link_valid_o=1 in cycle t+2; credit_cnt=3 in t+2.
REQ-041 Credit exhaustion: 5 consecutive writes, no credit returns -> 4 flits out in order, 5th held; one link_credit_i pulse -> 5th sent the following cycle.
REQ-042 Full/drop: credits at 0, 4 writes -> port_full=1; 5th write -> drop_err=1, FIFO contents unchanged, later drained in order.
REQ-043 Simultaneous: pop and link_credit_i in the same cycle at credit_cnt=2 -> credit_cnt stays 2.
REQ-044 Overflow: link_credit_i at credit_cnt=4 with FIFO empty -> credit_cnt=4, credit_err=1; write with in_select==PORT_ID -> credit_err=1.
